// File: rtl/pipe_add_pkg.sv
// Shared constants and stage-register layout for the pipelined adder/subtractor.
package pipe_add_pkg;

   localparam int unsigned PIPE_DEF_WIDTH  = 32;
   localparam int unsigned PIPE_DEF_STAGES = 4;

   // One pipeline stage at default width. The carry holds the chunk carry-out
   // and ovf the MSB-carry XOR carry-out. The lower sum chunks are completed,
   // while the upper operand chunks are still to be added.
   typedef struct packed {
      logic                      valid;
      logic                      sub;
      logic                      carry;
      logic                      ovf;
      logic [PIPE_DEF_WIDTH-1:0] a;
      logic [PIPE_DEF_WIDTH-1:0] b;
      logic [PIPE_DEF_WIDTH-1:0] sum;
   } pipe_stage_t;

endpackage

// File: rtl/add_chunk.sv
// Purely combinational CW-bit ripple adder. It also exposes the carry into its MSB.
module add_chunk #(
   parameter int unsigned CW = 8
) (
   input  logic [CW-1:0] a,
   input  logic [CW-1:0] b,
   input  logic          cin,
   output logic [CW-1:0] sum,
   output logic          cout,
   output logic          c_msb
);

   logic c_w;

   // Ripple the carry bit by bit and capture the carry entering the top bit.
   always_comb begin
      c_w   = cin;
      sum   = '0;
      c_msb = cin;
      for (int unsigned i = 0; i < CW; i++) begin
         if (i == CW - 1) c_msb = c_w;
         sum[i] = a[i] ^ b[i] ^ c_w;
         c_w    = (a[i] & b[i]) | (c_w & (a[i] ^ b[i]));
      end
      cout = c_w;
   end

endmodule

// File: rtl/pipe_add_sub.sv
// Pipelined add/subtract with a valid/ready handshake.
// Stage k adds operand chunk k. Pipeline bubbles collapse under backpressure.
module pipe_add_sub
   import pipe_add_pkg::*;
#(
   parameter int unsigned WIDTH  = PIPE_DEF_WIDTH,
   parameter int unsigned STAGES = PIPE_DEF_STAGES
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
   input  logic             in_sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic             out_ovf
);

   localparam int unsigned ST_SAFE = (STAGES < 1) ? 1 : STAGES;
   localparam int unsigned CW      = WIDTH / ST_SAFE;

   if ((STAGES < 1) || (WIDTH % ST_SAFE != 0)) begin : g_bad_cfg
      $error("pipe_add_sub: STAGES must be >= 1 and divide WIDTH");
   end

   // Width-parameterised form of pipe_stage_t
   typedef struct packed {
      logic             valid;
      logic             sub;
      logic             carry;
      logic             ovf;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [WIDTH-1:0] sum;
   } stg_t;

   logic rdy_q;

   for (genvar k = 0; k < STAGES; k++) begin : g_stg
      stg_t          src_w;
      stg_t          st_d;
      stg_t          st_q;
      logic          adv_w;
      logic [CW-1:0] b_eff_w;
      logic [CW-1:0] sum_w;
      logic          cout_w;
      logic          cmsb_w;

      if (k == 0) begin : g_src_in
         // Entry stage: subtract is a + ~b + 1, so the initial carry is forced high.
         always_comb begin
            src_w       = '0;
            src_w.valid = in_valid & in_ready;
            src_w.sub   = in_sub;
            src_w.carry = in_sub | in_cin;
            src_w.a     = in_a;
            src_w.b     = in_b;
         end
      end else begin : g_src_prev
         assign src_w = g_stg[k-1].st_q;
      end

      if (k == STAGES - 1) begin : g_adv_last
         assign adv_w = !st_q.valid | out_ready;
      end else begin : g_adv_mid
         assign adv_w = !st_q.valid | g_stg[k+1].adv_w;
      end

      assign b_eff_w = src_w.b[k*CW +: CW] ^ {CW{src_w.sub}};

      add_chunk #(
         .CW (CW)
      ) u_add_chunk (
         .a     (src_w.a[k*CW +: CW]),
         .b     (b_eff_w),
         .cin   (src_w.carry),
         .sum   (sum_w),
         .cout  (cout_w),
         .c_msb (cmsb_w)
      );

      // Load the upstream transaction with chunk k resolved, or hold while stalled.
      always_comb begin
         st_d = st_q;
         if (adv_w) begin
            st_d                  = src_w;
            st_d.carry            = cout_w;
            st_d.ovf              = cmsb_w ^ cout_w;
            st_d.sum[k*CW +: CW]  = sum_w;
         end
      end

      // Stage register. Reset discards whatever is in flight.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) st_q <= '0;
         else        st_q <= st_d;
      end
   end

   // Keep input acceptance off until the first clock edge after reset release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rdy_q <= 1'b0;
      else        rdy_q <= 1'b1;
   end

   assign in_ready  = rdy_q & g_stg[0].adv_w;
   assign out_valid = g_stg[STAGES-1].st_q.valid;
   assign out_sum   = g_stg[STAGES-1].st_q.sum;
   assign out_cout  = g_stg[STAGES-1].st_q.carry;
   assign out_ovf   = g_stg[STAGES-1].st_q.ovf;

endmodule

// File: tb/tb_pipe_add_sub.sv
// Randomised and directed bench for pipe_add_sub with an arithmetic reference model.
module tb_pipe_add_sub;

   localparam int unsigned W  = 32;
   localparam int unsigned NS = 4;
   localparam int unsigned N_RAND = 20000;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_a;
   logic [W-1:0]  in_b;
   logic          in_cin;
   logic          in_sub;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_sum;
   logic          out_cout;
   logic          out_ovf;

   typedef struct {
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
   } exp_t;

   exp_t exp_q[$];
   int   n_chk = 0;
   int   n_err = 0;
   int   n_out = 0;
   logic rdy_chk_en = 1'b0;
   logic rand_done  = 1'b0;

   pipe_add_sub #(
      .WIDTH  (W),
      .STAGES (NS)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_cin    (in_cin),
      .in_sub    (in_sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_cout  (out_cout),
      .out_ovf   (out_ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference: plain unsigned/signed integer arithmetic
   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic cin, input logic sub);
      exp_t   e;
      longint ua, ub, sa, sb, r, s;
      ua = longint'(a);
      ub = longint'(b);
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (sub) begin
         r      = ua - ub;
         s      = sa - sb;
         e.cout = (ua >= ub);
      end else begin
         r      = ua + ub + longint'(cin);
         s      = sa + sb + longint'(cin);
         e.cout = r[32];
      end
      e.sum = r[31:0];
      e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      return e;
   endfunction

   function automatic logic [W-1:0] rnd_op();
      case ($urandom_range(0, 7))
         0:       return '0;
         1:       return '1;
         2:       return 32'h8000_0000;
         3:       return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   // Scoreboard: the outputs must match the oldest outstanding transaction
   // (even while stalled). in_ready must be low exactly when four are held
   // and out_ready is low.
   always @(negedge clk) begin
      int occ;
      occ = exp_q.size();
      if (rdy_chk_en)
         chk("in_ready", in_ready, !((occ == NS) && !out_ready));
      if (out_valid) begin
         if (occ == 0) chk("spurious_out", 1, 0);
         else begin
            chk("sum",  out_sum,  exp_q[0].sum);
            chk("cout", out_cout, exp_q[0].cout);
            chk("ovf",  out_ovf,  exp_q[0].ovf);
            if (out_ready) begin
               void'(exp_q.pop_front());
               n_out++;
            end
         end
      end
      if (in_valid && in_ready)
         exp_q.push_back(model(in_a, in_b, in_cin, in_sub));
   end

   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, input logic sub);
      int t = 0;
      in_valid = 1'b1; in_a = a; in_b = b; in_cin = cin; in_sub = sub;
      forever begin
         @(negedge clk);
         if (in_ready) break;
         t++;
         if (t > 1000) begin chk("accept_timeout", 0, 1); break; end
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic run_one(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          input logic sub, input logic [W-1:0] e_sum, input logic e_cout,
                          input logic e_ovf, input string tag);
      int lat = 1;
      out_ready = 1'b1;
      send(a, b, cin, sub);
      forever begin
         @(negedge clk);
         if (out_valid || lat > 20) break;
         @(posedge clk); #1;
         lat++;
      end
      chk({tag, "_lat"},  lat,      NS);
      chk({tag, "_sum"},  out_sum,  e_sum);
      chk({tag, "_cout"}, out_cout, e_cout);
      chk({tag, "_ovf"},  out_ovf,  e_ovf);
      @(posedge clk); #1;
   endtask

   task automatic drain(input string tag);
      out_ready = 1'b1;
      for (int t = 0; t < 200; t++) begin
         @(negedge clk);
         if (exp_q.size() == 0) break;
      end
      @(negedge clk);
      chk(tag, exp_q.size(), 0);
      @(posedge clk); #1;
   endtask

   initial begin
      #5000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int base, cyc_i, sent;
      logic saw_stall;
      rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
      in_cin = 1'b0; in_sub = 1'b0; out_ready = 1'b0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_valid", out_valid, 0);
      chk("rst_sum",   out_sum,   0);
      chk("rst_cout",  out_cout,  0);
      chk("rst_ovf",   out_ovf,   0);
      chk("rst_ready", in_ready,  0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("ready_pre_edge", in_ready, 0);
      @(negedge clk);
      chk("ready_post_edge", in_ready, 1);
      @(posedge clk); #1;

      run_one(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, "add_wrap");
      run_one(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, "sub_minovf");
      run_one(32'h0000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, "sub_borrow");
      run_one(32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h8000_0000, 1'b0, 1'b1, "add_cin_ovf");
      run_one(32'h0000_0005, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0002, 1'b1, 1'b0, "sub_cin_ign");
      drain("directed_drain");

      // Ten back-to-back transactions with a downstream stall in cycles 3-8
      rdy_chk_en = 1'b1;
      base = n_out; sent = 0; cyc_i = 0; saw_stall = 1'b0;
      while (sent < 10 && cyc_i < 100) begin
         out_ready = !(cyc_i >= 3 && cyc_i <= 8);
         in_valid  = 1'b1;
         in_a = rnd_op(); in_b = rnd_op();
         in_cin = 1'($urandom_range(0, 1)); in_sub = 1'($urandom_range(0, 1));
         @(negedge clk);
         if (in_ready) sent++;
         else          saw_stall = 1'b1;
         @(posedge clk); #1;
         cyc_i++;
      end
      in_valid = 1'b0;
      drain("burst_drain");
      chk("burst_stall_seen", saw_stall, 1);
      chk("burst_count", n_out - base, 10);

      // Random valid/ready traffic
      fork
         begin
            for (int n = 0; n < N_RAND; n++) begin
               while ($urandom_range(0, 3) == 0) begin
                  in_valid = 1'b0;
                  @(posedge clk); #1;
               end
               send(rnd_op(), rnd_op(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
            rand_done = 1'b1;
         end
         begin
            while (!rand_done) begin
               out_ready = ($urandom_range(0, 3) != 0);
               @(posedge clk); #1;
            end
         end
      join
      drain("random_drain");
      rdy_chk_en = 1'b0;

      // Reset while three transactions are in flight and the head is stalled at the output
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_a = 32'h1234_5678 + i; in_b = 32'h0101_0101;
         in_cin = 1'b0; in_sub = 1'b0;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      for (int t = 0; t < 20; t++) begin
         @(negedge clk);
         if (out_valid) break;
      end
      chk("flight_head_valid", out_valid, 1);
      #2;
      rst_n = 1'b0;
      exp_q.delete();
      #1;
      chk("async_rst_valid", out_valid, 0);
      chk("async_rst_sum",   out_sum,   0);
      chk("async_rst_cout",  out_cout,  0);
      chk("async_rst_ready", in_ready,  0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      out_ready = 1'b1;
      for (int t = 0; t < 8; t++) begin
         @(negedge clk);
         chk("no_stale_out", out_valid, 0);
      end
      chk("ready_after_rst", in_ready, 1);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
